// File: rtl/rv_muldiv.sv
// RISC-V M-extension multiply/divide unit: iterative shift-add multiply and restoring divide.
// Optional macro URV_MULDIV_FAST_MUL_EN: multiplies are computed in one step during PREP.
module rv_muldiv #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       fun_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    input  logic             kill_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             stall_req_o
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2:0]           r_fun;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH:0]     r_prod;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH:0]       r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_div;
    logic [WIDTH-1:0]     r_result;

    logic                 w_is_div;
    logic                 w_a_signed;
    logic                 w_b_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 w_div_zero;
    logic                 w_ovf;
    logic                 w_fast;
    logic [2*WIDTH:0]     w_prod_nxt;
    logic [2*WIDTH:0]     w_div_nxt;

    // Shift-add: the carry out of the upper-half add lands in bit 2*WIDTH before the shift.
    function automatic logic [2*WIDTH:0] mul_step(input logic [2*WIDTH:0] p,
                                                  input logic [WIDTH-1:0] m);
        logic [2*WIDTH:0] t;
        t = p;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (t[0])
                t[2*WIDTH:WIDTH] = t[2*WIDTH:WIDTH] + {1'b0, m};
            t = t >> 1;
        end
        return t;
    endfunction

    function automatic logic [2*WIDTH:0] div_step(input logic [WIDTH:0]   rem,
                                                  input logic [WIDTH-1:0] quo,
                                                  input logic [WIDTH-1:0] d);
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] q;
        r = rem;
        q = quo;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            r = {r[WIDTH-1:0], q[WIDTH-1]};
            q = {q[WIDTH-2:0], 1'b0};
            if (r >= {1'b0, d}) begin
                r    = r - {1'b0, d};
                q[0] = 1'b1;
            end
        end
        return {r, q};
    endfunction

    function automatic logic [WIDTH-1:0] mul_result(input logic [2:0]         fun,
                                                    input logic [2*WIDTH-1:0] p,
                                                    input logic               neg);
        logic [2*WIDTH-1:0] s;
        s = neg ? -p : p;
        return (fun[1:0] == 2'b00) ? s[WIDTH-1:0] : s[2*WIDTH-1:WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] div_result(input logic [2:0]       fun,
                                                    input logic [WIDTH-1:0] q,
                                                    input logic [WIDTH-1:0] r,
                                                    input logic             neg_q,
                                                    input logic             neg_r);
        if (fun[1])
            return neg_r ? -r : r;
        return neg_q ? -q : q;
    endfunction

    // Operand decode from the latched request
    assign w_is_div   = r_fun[2];
    assign w_a_signed = (r_fun == 3'b001) || (r_fun == 3'b010) ||
                        (r_fun == 3'b100) || (r_fun == 3'b110);
    assign w_b_signed = (r_fun == 3'b001) || (r_fun == 3'b100) || (r_fun == 3'b110);
    assign w_a_neg    = w_a_signed & r_a[WIDTH-1];
    assign w_b_neg    = w_b_signed & r_b[WIDTH-1];
    assign w_mag_a    = w_a_neg ? -r_a : r_a;
    assign w_mag_b    = w_b_neg ? -r_b : r_b;
    assign w_div_zero = w_is_div && (r_b == '0);
    assign w_ovf      = w_is_div && !r_fun[0] && (r_b == '1) &&
                        (r_a == {1'b1, {(WIDTH-1){1'b0}}});

    assign w_prod_nxt = mul_step(r_prod, r_mcand);
    assign w_div_nxt  = div_step(r_rem, r_quo, r_div);

`ifdef URV_MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_prod;
    assign w_fast_prod = (2*WIDTH)'(w_mag_a) * (2*WIDTH)'(w_mag_b);
    assign w_fast      = !w_is_div;
`else
    assign w_fast      = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = (r_state != S_IDLE);
        done_o      = (r_state == S_FIX);
        stall_req_o = ((r_state == S_IDLE) && start_i) ||
                      (r_state == S_PREP) || (r_state == S_CALC);
        case (r_state)
            S_IDLE: begin
                if (start_i && !kill_i)
                    w_state_nxt = S_PREP;
            end
            S_PREP: begin
                if (kill_i)
                    w_state_nxt = S_IDLE;
                else if (w_div_zero || w_ovf || w_fast)
                    w_state_nxt = S_FIX;
                else
                    w_state_nxt = S_CALC;
            end
            S_CALC: begin
                if (kill_i)
                    w_state_nxt = S_IDLE;
                else if (r_cnt == CNT_LAST)
                    w_state_nxt = S_FIX;
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fun    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i && !kill_i) begin
                        r_fun <= fun_i;
                        r_a   <= rs1_i;
                        r_b   <= rs2_i;
                    end
                end
                // Load both engines; only the one selected by r_fun matters
                S_PREP: begin
                    if (!kill_i) begin
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_cnt   <= '0;
                        r_prod  <= {{(WIDTH+1){1'b0}}, w_mag_b};
                        r_mcand <= w_mag_a;
                        r_rem   <= '0;
                        r_quo   <= w_mag_a;
                        r_div   <= w_mag_b;
                        if (w_div_zero)
                            r_result <= r_fun[1] ? r_a : '1;
                        else if (w_ovf)
                            r_result <= r_fun[1] ? '0 : r_a;
`ifdef URV_MULDIV_FAST_MUL_EN
                        else if (w_fast)
                            r_result <= mul_result(r_fun, w_fast_prod, w_a_neg ^ w_b_neg);
`endif
                    end
                end
                S_CALC: begin
                    if (!kill_i) begin
                        r_cnt  <= r_cnt + CW'(1);
                        r_prod <= w_prod_nxt;
                        {r_rem, r_quo} <= w_div_nxt;
                        if (r_cnt == CNT_LAST) begin
                            if (w_is_div)
                                r_result <= div_result(r_fun, w_div_nxt[WIDTH-1:0],
                                                       w_div_nxt[2*WIDTH-1:WIDTH],
                                                       r_neg_q, r_neg_r);
                            else
                                r_result <= mul_result(r_fun, w_prod_nxt[2*WIDTH-1:0], r_neg_q);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result_o = r_result;

endmodule

// File: tb/tb_rv_muldiv.sv
// Randomized self-checking bench for rv_muldiv against an arithmetic reference model.
module tb_rv_muldiv;
    localparam int WIDTH  = 32;
    localparam int BPC    = 1;
    localparam int N      = WIDTH / BPC;
    localparam int BUDGET = N + 20;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [2:0]       fun_i;
    logic [WIDTH-1:0] rs1_i;
    logic [WIDTH-1:0] rs2_i;
    logic             kill_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             stall_req_o;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [31:0]      last_result;

    always #5 clk = ~clk;

    rv_muldiv #(.WIDTH(WIDTH), .BITS_PER_CYCLE(BPC)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .fun_i      (fun_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .kill_i     (kill_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .stall_req_o(stall_req_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic        [63:0] up;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * $signed({32'd0, b}); return sp[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                sp = sa / sb; return sp[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                sp = sa % sb; return sp[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0)) return 2;
        if (f[2] && !f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 2;
`ifdef URV_MULDIV_FAST_MUL_EN
        if (!f[2]) return 2;
`endif
        return N + 2;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit inject, input bit kill_fix);
        int          lat, cyc, stall_cnt;
        bit          seen;
        logic [31:0] exp;
        exp       = model(f, a, b);
        lat       = exp_lat(f, a, b);
        start_i   = 1'b1;
        fun_i     = f;
        rs1_i     = a;
        rs2_i     = b;
        #1;
        stall_cnt = stall_req_o ? 1 : 0;
        seen      = 1'b0;
        cyc       = 0;
        while (!seen && cyc < BUDGET) begin
            @(posedge clk);
            #1;
            cyc++;
            start_i = inject && (cyc == 1);
            fun_i   = 3'($urandom);
            rs1_i   = $urandom;
            rs2_i   = $urandom;
            @(negedge clk);
            if (done_o) seen = 1'b1;
            else if (stall_req_o) stall_cnt++;
        end
        check({tag, " done"}, seen, 1);
        check({tag, " latency"}, cyc, lat);
        check({tag, " result"}, result_o, exp);
        check({tag, " stall cycles"}, stall_cnt, lat);
        check({tag, " stall in FIX"}, stall_req_o, 0);
        if (kill_fix) kill_i = 1'b1;
        @(posedge clk);
        #1;
        kill_i = 1'b0;
        @(negedge clk);
        check({tag, " done width"}, done_o, 0);
        check({tag, " idle after"}, busy_o, 0);
        check({tag, " result held"}, result_o, exp);
        last_result = exp;
    endtask

    initial begin
        logic [31:0] corners [6];
        logic [31:0] a, b;
        int          dones;
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
        rst_i   = 1'b1;
        start_i = 1'b0;
        kill_i  = 1'b0;
        fun_i   = '0;
        rs1_i   = '0;
        rs2_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("reset busy", busy_o, 0);
        check("reset done", done_o, 0);
        check("reset result", result_o, 0);
        check("reset stall", stall_req_o, 0);
        last_result = '0;

        run_op("MUL 7xFFFFFFFD", 3'd0, 32'd7, 32'hFFFF_FFFD, 0, 0);
        check("MUL literal", last_result, 32'hFFFF_FFEB);
        run_op("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 0, 0);
        run_op("MULHSU -1*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 0, 0);
        run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 0, 0);
        run_op("DIVU 5/0", 3'd5, 32'd5, 32'd0, 0, 0);
        run_op("REM 5/0", 3'd6, 32'd5, 32'd0, 0, 0);
        run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op("DIVU kill in FIX", 3'd5, 32'd1000, 32'd3, 0, 1);

        // Kill a divide at cycle 10, then start a multiply at cycle 11
        start_i = 1'b1; fun_i = 3'd4; rs1_i = 32'd12345; rs2_i = 32'd17;
        dones = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
            @(negedge clk);
            if (done_o) dones++;
        end
        kill_i = 1'b1;
        @(posedge clk);
        #1;
        kill_i = 1'b0;
        @(negedge clk);
        if (done_o) dones++;
        check("kill busy", busy_o, 0);
        check("kill no done", dones, 0);
        check("kill result held", result_o, last_result);
        run_op("MUL 3x4 after kill", 3'd0, 32'd3, 32'd4, 0, 0);

        // Start together with kill in IDLE is rejected
        start_i = 1'b1; kill_i = 1'b1; fun_i = 3'd5; rs1_i = 32'd9; rs2_i = 32'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0; kill_i = 1'b0;
        @(negedge clk);
        check("start+kill idle", busy_o, 0);

        // Reset in the middle of a multiply
        start_i = 1'b1; fun_i = 3'd3; rs1_i = 32'hDEAD_BEEF; rs2_i = 32'h1234_5678;
        repeat (6) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
        end
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("midrst busy", busy_o, 0);
        check("midrst result", result_o, 0);
        check("midrst stall", stall_req_o, 0);
        dones = 0;
        repeat (N + 4) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        check("midrst no done", dones, 0);
        last_result = '0;

        for (int k = 0; k < 250; k++) begin
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 7) == 0) b = b >> $urandom_range(16, 31);
            run_op($sformatf("rnd%0d", k), 3'($urandom_range(0, 7)), a, b,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_muldiv.md
RV_MULDIV -- requirements
Module: rv_muldiv

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits, even, at least 8.
REQ-002 Parameter BITS_PER_CYCLE, default 1: iteration bits per CALC cycle; one of 1, 2, 4; divides WIDTH; N = WIDTH/BITS_PER_CYCLE.
REQ-003 clk_i  in  1  clock; single clock domain, all state on rising edge.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 start_i  in  1  request; accepted only in IDLE.
REQ-006 fun_i  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 rs1_i, rs2_i  in  WIDTH each  operands; sampled only in the start cycle.
REQ-008 kill_i  in  1  abort the operation in flight.
REQ-009 busy_o  out  1  high in any state other than IDLE.
REQ-010 done_o  out  1  one-cycle pulse; result_o valid.
REQ-011 result_o  out  WIDTH  result; held from done_o until the next accepted start.
REQ-012 stall_req_o  out  1  pipeline stall request.

Function
REQ-013 States: IDLE, PREP, CALC, FIX. IDLE->PREP on start_i. PREP->CALC. CALC->FIX after N cycles. FIX->IDLE. done_o is asserted in the FIX cycle.
REQ-014 PREP: latch fun_i and take magnitudes of signed operands: rs1 for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM. Record the result sign.
REQ-015 MUL ops: shift-add over a 2*WIDTH product, BITS_PER_CYCLE multiplier bits per cycle.
REQ-016 MUL returns low WIDTH bits; MULH, MULHSU and MULHU return high WIDTH bits of the signed/signed, signed/unsigned and unsigned/unsigned product.
REQ-017 DIV ops: restoring division, BITS_PER_CYCLE quotient bits per cycle.
REQ-018 DIV ops, sign rules: quotient is negated when operand signs differ; remainder takes the sign of the dividend.
REQ-019 Latency: done_o exactly N+2 cycles after the start cycle (start at cycle 0).
REQ-020 Divide by zero: quotient = all ones; remainder = rs1. PREP goes directly to FIX; done_o at cycle 2.
REQ-021 Signed overflow (DIV/REM of -2^(WIDTH-1) by -1): quotient = rs1; remainder = 0. PREP goes directly to FIX; done_o at cycle 2.
REQ-022 stall_req_o = (start_i AND IDLE) OR PREP OR CALC (combinational); low in the FIX cycle.
REQ-023 start_i while busy_o is high is ignored; no queuing.
REQ-024 kill_i in PREP or CALC: next state IDLE, no done_o, result_o unchanged.
REQ-025 kill_i in the FIX cycle has no effect.
REQ-026 kill_i together with start_i in IDLE: start rejected, state stays IDLE.

Reset
REQ-027 rst_i: state IDLE; result_o=0, done_o=0, busy_o=0, stall_req_o=0 from the next cycle.
REQ-028 Reset mid-operation discards the operation: no done_o, internal accumulators cleared.
REQ-029 rst_i has priority over kill_i and start_i.

Configuration
REQ-030 Macro URV_MULDIV_FAST_MUL_EN defined: MUL ops compute the full product combinationally in PREP, skip CALC, and assert done_o at cycle 2.
REQ-031 URV_MULDIV_FAST_MUL_EN undefined: MUL ops are iterative per REQ-015, done_o at cycle N+2, no WIDTH x WIDTH multiplier instantiated.
REQ-032 Divide timing and all other behaviour are identical with and without the macro.

Verification (WIDTH=32, BITS_PER_CYCLE=1, macro undefined unless stated)
REQ-033 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done_o at cycle 34, stall_req_o high cycles 0-33.
REQ-034 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU the same operands -> 0xFFFFFFFE.
REQ-035 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
REQ-036 DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, both done_o at cycle 2; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-037 Run DIV, pulse kill_i at cycle 10 -> busy_o low at cycle 11, no done_o. Start MUL 3x4 at cycle 11 -> result 12 at cycle 45.
REQ-038 Macro defined, MUL 3 x 4 -> result 12, done_o at cycle 2. Repeat with BITS_PER_CYCLE=4 and DIVU 100/7 -> 14, done_o at cycle 10.
